// File: rtl/agu_sequencer_pkg.sv
// Shared definitions for the AGU job sequencer: default widths and FSM state encoding.
package agu_sequencer_pkg;

    localparam int DEF_BWADDR   = 21;
    localparam int DEF_BWLENGTH = 8;
    localparam int DEF_BWCOUNT  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    function automatic logic is_busy(input seq_state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/agu_sequencer_agu.sv
// Four-dimensional address generator: nested counters, each wrap selects the next outer jump.
module agu_sequencer_agu import agu_sequencer_pkg::*; #(
    parameter int BWADDR   = DEF_BWADDR,
    parameter int BWLENGTH = DEF_BWLENGTH
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                step,
    input  logic [BWLENGTH-1:0] l0,
    input  logic [BWLENGTH-1:0] l1,
    input  logic [BWLENGTH-1:0] l2,
    input  logic [BWLENGTH-1:0] l3,
    input  logic [BWADDR-1:0]   j0,
    input  logic [BWADDR-1:0]   j1,
    input  logic [BWADDR-1:0]   j2,
    input  logic [BWADDR-1:0]   j3,
    input  logic [BWADDR-1:0]   j4,
    output logic [BWADDR-1:0]   addr,
    output logic [3:0]          z
);

    logic [BWLENGTH-1:0] cnt0, cnt1, cnt2, cnt3;
    logic [BWADDR-1:0]   acc;
    logic [BWADDR-1:0]   jump;
    logic                w0, w1, w2, w3;

    // wN means every dimension up to N is at its last position, so this step wraps them all
    always_comb begin
        w0 = (cnt0 == l0);
        w1 = w0 && (cnt1 == l1);
        w2 = w1 && (cnt2 == l2);
        w3 = w2 && (cnt3 == l3);
        if (!w0) begin
            jump = j0;
        end else if (!w1) begin
            jump = j1;
        end else if (!w2) begin
            jump = j2;
        end else if (!w3) begin
            jump = j3;
        end else begin
            jump = j4;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
            cnt2 <= '0;
            cnt3 <= '0;
            acc  <= '0;
        end else if (step) begin
            cnt0 <= w0 ? '0 : cnt0 + 1'b1;
            if (w0) begin
                cnt1 <= w1 ? '0 : cnt1 + 1'b1;
            end
            if (w1) begin
                cnt2 <= w2 ? '0 : cnt2 + 1'b1;
            end
            if (w2) begin
                cnt3 <= w3 ? '0 : cnt3 + 1'b1;
            end
            acc <= acc + jump;
        end
    end

    assign addr = acc;
    assign z    = {w3, w2, w1, w0};

endmodule

// File: rtl/agu_sequencer.sv
// Job sequencer around one AGU: latches a job on start, streams count addresses with
// valid/ready handshaking, then pulses done.
module agu_sequencer import agu_sequencer_pkg::*; #(
    parameter int BWADDR   = DEF_BWADDR,
    parameter int BWLENGTH = DEF_BWLENGTH,
    parameter int BWCOUNT  = DEF_BWCOUNT
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic                abort,
    input  logic [BWLENGTH-1:0] l0,
    input  logic [BWLENGTH-1:0] l1,
    input  logic [BWLENGTH-1:0] l2,
    input  logic [BWLENGTH-1:0] l3,
    input  logic [BWADDR-1:0]   j0,
    input  logic [BWADDR-1:0]   j1,
    input  logic [BWADDR-1:0]   j2,
    input  logic [BWADDR-1:0]   j3,
    input  logic [BWADDR-1:0]   j4,
    input  logic [BWADDR-1:0]   base,
    input  logic [BWCOUNT-1:0]  count,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BWADDR-1:0]   out_addr,
    output logic [3:0]          out_z,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    seq_state_t          state, next_state;
    logic [BWLENGTH-1:0] sh_l0, sh_l1, sh_l2, sh_l3;
    logic [BWADDR-1:0]   sh_j0, sh_j1, sh_j2, sh_j3, sh_j4;
    logic [BWADDR-1:0]   sh_base;
    logic [BWCOUNT-1:0]  sh_count;
    logic [BWCOUNT-1:0]  remaining;
    logic                handshake;
    logic                agu_clr;
    logic [BWADDR-1:0]   agu_addr;
    logic [3:0]          agu_z;

    assign handshake = out_valid && out_ready;
    assign agu_clr   = clr || (state == ST_LOAD);

    // The job is captured only when a start is accepted, so the inputs are free to change mid-job
    always_ff @(posedge clk) begin
        if (clr) begin
            sh_l0    <= '0;
            sh_l1    <= '0;
            sh_l2    <= '0;
            sh_l3    <= '0;
            sh_j0    <= '0;
            sh_j1    <= '0;
            sh_j2    <= '0;
            sh_j3    <= '0;
            sh_j4    <= '0;
            sh_base  <= '0;
            sh_count <= '0;
        end else if (state == ST_IDLE && start) begin
            sh_l0    <= l0;
            sh_l1    <= l1;
            sh_l2    <= l2;
            sh_l3    <= l3;
            sh_j0    <= j0;
            sh_j1    <= j1;
            sh_j2    <= j2;
            sh_j3    <= j3;
            sh_j4    <= j4;
            sh_base  <= base;
            sh_count <= count;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            remaining <= '0;
        end else if (state == ST_LOAD) begin
            remaining <= sh_count;
        end else if (handshake) begin
            remaining <= remaining - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else if (sh_count != '0) begin
                    next_state = ST_RUN;
                end else begin
                    next_state = ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else if (handshake && out_last) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // An abort arriving in DONE suppresses the completion pulse in that same cycle
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = is_busy(state);
        case (state)
            ST_RUN: begin
                out_valid = 1'b1;
                out_last  = (remaining == BWCOUNT'(1));
            end
            ST_DONE: done = !abort;
            default: ;
        endcase
    end

    agu_sequencer_agu #(
        .BWADDR   (BWADDR),
        .BWLENGTH (BWLENGTH)
    ) u_agu (
        .clk  (clk),
        .clr  (agu_clr),
        .step (handshake),
        .l0   (sh_l0),
        .l1   (sh_l1),
        .l2   (sh_l2),
        .l3   (sh_l3),
        .j0   (sh_j0),
        .j1   (sh_j1),
        .j2   (sh_j2),
        .j3   (sh_j3),
        .j4   (sh_j4),
        .addr (agu_addr),
        .z    (agu_z)
    );

    assign out_addr = sh_base + agu_addr;
    assign out_z    = out_valid ? agu_z : 4'b0000;

endmodule

// File: tb/tb_agu_sequencer.sv
// Self-checking bench for agu_sequencer: nested-loop reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized soak.
module tb_agu_sequencer;

    typedef enum int {M_IDLE, M_LOAD, M_RUN, M_DONE} model_state_t;

    localparam int EXP034 [6] = '{100, 101, 102, 112, 113, 114};
    localparam int EXP039 [3] = '{2097149, 4, 11};

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        abort;
    logic [7:0]  l0, l1, l2, l3;
    logic [20:0] j0, j1, j2, j3, j4;
    logic [20:0] base;
    logic [15:0] count;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] out_addr;
    logic [3:0]  out_z;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_fail = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int stall_cnt = 0;

    model_state_t mstate = M_IDLE;
    logic [20:0]  mq[$];
    logic [3:0]   mzq[$];
    logic [20:0]  ref_addr[$];
    logic [3:0]   ref_z[$];
    logic [20:0]  hs_log[$];
    int           exp_log[$];

    agu_sequencer dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .abort     (abort),
        .l0        (l0),
        .l1        (l1),
        .l2        (l2),
        .l3        (l3),
        .j0        (j0),
        .j1        (j1),
        .j2        (j2),
        .j3        (j3),
        .j4        (j4),
        .base      (base),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_z     (out_z),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the loop nest directly: innermost dimension first, jump chosen by the innermost non-wrapping loop
    task automatic buildJob(input logic [20:0] b, input logic [7:0] a0, a1, a2, a3,
                            input logic [20:0] k0, k1, k2, k3, k4, input int n);
        logic [20:0] a;
        logic [3:0]  zz;
        ref_addr.delete();
        ref_z.delete();
        a = b;
        while (ref_addr.size() < n) begin
            for (int d3 = 0; d3 <= int'(a3) && ref_addr.size() < n; d3++)
                for (int d2 = 0; d2 <= int'(a2) && ref_addr.size() < n; d2++)
                    for (int d1 = 0; d1 <= int'(a1) && ref_addr.size() < n; d1++)
                        for (int d0 = 0; d0 <= int'(a0) && ref_addr.size() < n; d0++) begin
                            zz[0] = (d0 == int'(a0));
                            zz[1] = zz[0] && (d1 == int'(a1));
                            zz[2] = zz[1] && (d2 == int'(a2));
                            zz[3] = zz[2] && (d3 == int'(a3));
                            ref_addr.push_back(a);
                            ref_z.push_back(zz);
                            if (!zz[0]) a = a + k0;
                            else if (!zz[1]) a = a + k1;
                            else if (!zz[2]) a = a + k2;
                            else if (!zz[3]) a = a + k3;
                            else a = a + k4;
                        end
        end
    endtask

    task automatic checkLog(input string name);
        checkOutput({name, "_len"}, 32'(hs_log.size()), 32'(exp_log.size()));
        foreach (exp_log[i]) begin
            checkOutput(name, (i < hs_log.size()) ? 32'(hs_log[i]) : 32'hFFFF_FFFF, 32'(exp_log[i]));
        end
    endtask

    task automatic checkRef(input string name);
        checkOutput({name, "_len"}, 32'(ref_addr.size()), 32'(exp_log.size()));
        foreach (exp_log[i]) begin
            checkOutput(name, (i < ref_addr.size()) ? 32'(ref_addr[i]) : 32'hFFFF_FFFF, 32'(exp_log[i]));
        end
    endtask

    // One compare process: check outputs at negedge, advance the model at posedge
    initial begin : compare_proc
        logic exp_valid;
        forever begin
            @(negedge clk);
            exp_valid = (mstate == M_RUN);
            checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
            checkOutput("busy", 32'(busy), 32'(mstate != M_IDLE));
            checkOutput("done", 32'(done), 32'(mstate == M_DONE && !abort));
            checkOutput("out_last", 32'(out_last), 32'(exp_valid && mq.size() == 1));
            if (exp_valid && mq.size() > 0) begin
                checkOutput("out_addr", 32'(out_addr), 32'(mq[0]));
                checkOutput("out_z", 32'(out_z), 32'(mzq[0]));
            end
            if (mstate == M_IDLE) checkOutput("out_z_idle", 32'(out_z), 32'd0);
            if (out_valid && out_ready) hs_log.push_back(out_addr);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (out_valid && !out_ready) stall_cnt++;
            @(posedge clk);
            if (clr) begin
                mstate = M_IDLE;
                mq.delete();
                mzq.delete();
            end else begin
                case (mstate)
                    M_IDLE: if (start) begin
                        buildJob(base, l0, l1, l2, l3, j0, j1, j2, j3, j4, int'(count));
                        mq = ref_addr;
                        mzq = ref_z;
                        mstate = M_LOAD;
                    end
                    M_LOAD: mstate = abort ? M_IDLE : (mq.size() == 0 ? M_DONE : M_RUN);
                    M_RUN: begin
                        if (out_ready && mq.size() > 0) begin
                            void'(mq.pop_front());
                            void'(mzq.pop_front());
                        end
                        if (abort) mstate = M_IDLE;
                        else if (out_ready && mq.size() == 0) mstate = M_DONE;
                    end
                    M_DONE: mstate = M_IDLE;
                    default: mstate = M_IDLE;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [20:0] b, input logic [7:0] a0, a1, a2, a3,
                                 input logic [20:0] k0, k1, k2, k3, k4,
                                 input logic [15:0] n, input logic with_abort);
        tick();
        base = b; l0 = a0; l1 = a1; l2 = a2; l3 = a3;
        j0 = k0; j1 = k1; j2 = k2; j3 = k3; j4 = k4;
        count = n;
        start = 1'b1;
        abort = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int i = 0;
        while (busy && i < budget) begin
            tick();
            i++;
        end
        checkOutput("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic job034(input logic with_abort);
        applyStimulus(21'd100, 8'd2, 8'd5, 8'd5, 8'd5, 21'd1, 21'd10, 21'd0, 21'd0, 21'd0,
                      16'd6, with_abort);
    endtask

    initial begin : stimulus_proc
        int i;
        clr = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        l0 = '0; l1 = '0; l2 = '0; l3 = '0;
        j0 = '0; j1 = '0; j2 = '0; j3 = '0; j4 = '0;
        base = '0; count = '0;
        repeat (3) tick();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        clr = 1'b0;

        $display("[TB] pin the reference model against hand-computed sequences");
        buildJob(21'd100, 8'd2, 8'd5, 8'd5, 8'd5, 21'd1, 21'd10, 21'd0, 21'd0, 21'd0, 6);
        exp_log.delete();
        foreach (EXP034[k]) exp_log.push_back(EXP034[k]);
        checkRef("model034");
        checkOutput("model034_z2", 32'(ref_z[2]), 32'h1);
        checkOutput("model034_z0", 32'(ref_z[0]), 32'h0);
        buildJob(21'd2097149, 8'd0, 8'd0, 8'd0, 8'd0, 21'd0, 21'd0, 21'd0, 21'd0, 21'd7, 3);
        exp_log.delete();
        foreach (EXP039[k]) exp_log.push_back(EXP039[k]);
        checkRef("model039");
        checkOutput("model039_z", 32'(ref_z[0]), 32'hF);

        $display("[TB] basic 3D walk with latency check");
        hs_log.delete(); done_cnt = 0;
        job034(1'b0);
        tick();
        checkOutput("latency_valid", 32'(out_valid), 32'd1);
        checkOutput("latency_addr", 32'(out_addr), 32'd100);
        waitIdle(50);
        exp_log.delete();
        foreach (EXP034[k]) exp_log.push_back(EXP034[k]);
        checkLog("seq034");
        checkOutput("done034", 32'(done_cnt), 32'd1);

        $display("[TB] backpressure holds the address");
        hs_log.delete(); stall_cnt = 0;
        job034(1'b0);
        i = 0;
        while (!(out_valid && out_addr == 21'd101) && i < 20) begin
            tick();
            i++;
        end
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        waitIdle(50);
        checkLog("seq035");
        checkOutput("stall035", 32'(stall_cnt), 32'd3);

        $display("[TB] empty job");
        hs_log.delete(); busy_cnt = 0; done_cnt = 0;
        applyStimulus(21'd55, 8'd1, 8'd1, 8'd1, 8'd1, 21'd3, 21'd3, 21'd3, 21'd3, 21'd3, 16'd0, 1'b0);
        waitIdle(20);
        checkOutput("busy036", 32'(busy_cnt), 32'd2);
        checkOutput("done036", 32'(done_cnt), 32'd1);
        checkOutput("hs036", 32'(hs_log.size()), 32'd0);

        $display("[TB] abort in DONE suppresses completion");
        done_cnt = 0;
        applyStimulus(21'd55, 8'd0, 8'd0, 8'd0, 8'd0, 21'd0, 21'd0, 21'd0, 21'd0, 21'd0, 16'd0, 1'b0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_done_busy", 32'(busy), 32'd0);
        checkOutput("abort_done_cnt", 32'(done_cnt), 32'd0);

        $display("[TB] abort after the second handshake");
        hs_log.delete(); done_cnt = 0;
        job034(1'b0);
        i = 0;
        while (hs_log.size() < 2 && i < 20) begin
            tick();
            i++;
        end
        out_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_valid", 32'(out_valid), 32'd0);
        repeat (2) tick();
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);
        out_ready = 1'b1;
        hs_log.delete();
        job034(1'b0);
        tick();
        checkOutput("restart_first", 32'(out_addr), 32'd100);
        waitIdle(50);
        checkLog("seq037");

        $display("[TB] start while running is ignored");
        hs_log.delete();
        job034(1'b0);
        repeat (2) tick();
        base = 21'd5000; start = 1'b1;
        tick();
        start = 1'b0; base = 21'd100;
        waitIdle(50);
        checkLog("seq038");

        $display("[TB] address wrap with start+abort in IDLE");
        hs_log.delete();
        applyStimulus(21'd2097149, 8'd0, 8'd0, 8'd0, 8'd0, 21'd0, 21'd0, 21'd0, 21'd0, 21'd7,
                      16'd3, 1'b1);
        waitIdle(30);
        exp_log.delete();
        foreach (EXP039[k]) exp_log.push_back(EXP039[k]);
        checkLog("seq039");

        $display("[TB] clear mid-job");
        done_cnt = 0;
        job034(1'b0);
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("clr_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        checkOutput("clr_no_done", 32'(done_cnt), 32'd0);

        $display("[TB] randomized soak");
        for (int c = 0; c < 3000; c++) begin
            tick();
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 29) == 0);
            clr = ($urandom_range(0, 299) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            l0 = 8'($urandom_range(0, 3)); l1 = 8'($urandom_range(0, 3));
            l2 = 8'($urandom_range(0, 2)); l3 = 8'($urandom_range(0, 2));
            j0 = 21'($urandom()); j1 = 21'($urandom()); j2 = 21'($urandom());
            j3 = 21'($urandom()); j4 = 21'($urandom());
            base = 21'($urandom());
            count = 16'($urandom_range(0, 20));
        end
        tick();
        start = 1'b0; abort = 1'b0; clr = 1'b0; out_ready = 1'b1;
        waitIdle(100);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/agu_sequencer.md
AGU_SEQUENCER -- requirements
Module: agu_sequencer

Interface
REQ-001 SHALL have parameter BWADDR, default 21, meaning address bitwidth.
REQ-002 SHALL have parameter BWLENGTH, default 8, meaning per-dimension length bitwidth.
REQ-003 SHALL have parameter BWCOUNT, default 16, meaning job element-count bitwidth.
REQ-004 SHALL have port clk  input  1  clock; all logic rises on posedge clk.
REQ-005 SHALL have port clr  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port start  input  1  job launch request, sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  terminate current job.
REQ-008 SHALL have ports l0,l1,l2,l3  input  BWLENGTH each  per-dimension lengths (dimension N visits lN+1 positions).
REQ-009 SHALL have ports j0,j1,j2,j3,j4  input  BWADDR each  per-dimension address jumps.
REQ-010 SHALL have port base  input  BWADDR  job base address.
REQ-011 SHALL have port count  input  BWCOUNT  number of addresses to emit.
REQ-012 SHALL have port out_valid  output  1  out_addr valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts out_addr.
REQ-014 SHALL have port out_addr  output  BWADDR  generated address.
REQ-015 SHALL have port out_z  output  4  dimension-wrap flags {z3,z2,z1,z0}, meaningful on handshake only.
REQ-016 SHALL have port out_last  output  1  marks final address of job.
REQ-017 SHALL have ports busy  output  1 and done  output  1  (done: one-cycle completion pulse).

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-019 IDLE: on start=1, SHALL latch l0..l3, j0..j4, base, count into shadow registers and go to LOAD; shadow values SHALL NOT change until the next accepted start.
REQ-020 LOAD (one cycle): SHALL drive the internal AGU clear, go to RUN if latched count!=0, else to DONE.
REQ-021 RUN: out_valid SHALL be 1; out_addr SHALL equal (shadow base + AGU address) mod 2^BWADDR.
REQ-022 AGU step SHALL be out_valid & out_ready; out_addr and out_z SHALL hold stable while out_ready=0.
REQ-023 A remaining-count register SHALL load count in LOAD and decrement by 1 per handshake.
REQ-024 out_last SHALL be 1 in RUN when remaining==1; a handshake with out_last=1 SHALL move to DONE.
REQ-025 DONE (one cycle): done=1, then IDLE; done SHALL be 0 in all other states.
REQ-026 busy SHALL be 1 in LOAD, RUN, DONE; 0 in IDLE.
REQ-027 start outside IDLE SHALL be ignored with no effect on shadow registers.
REQ-028 abort=1 in LOAD/RUN/DONE SHALL force IDLE next cycle, out_valid=0 next cycle, no done pulse; abort overrides a same-cycle final handshake (that address counts as consumed, done still suppressed); abort in IDLE SHALL be ignored, start+abort in IDLE SHALL start.
REQ-029 Latency: start accepted at cycle t -> out_valid first 1 at t+2 with out_addr=base.

Reset
REQ-030 clr=1 SHALL force IDLE, out_valid=0, out_last=0, done=0, busy=0, out_z=0, remaining=0, and clear the internal AGU, overriding start/abort/handshake in that cycle.
REQ-031 clr mid-job SHALL discard the job with no done pulse.

Structure
REQ-032 State encoding and default parameter constants SHALL live in the shared package.
REQ-033 SHALL instantiate exactly one agu sub-module (datapath), with clr driven by (clr | LOAD-state) and step as per REQ-022; this block adds only control.

Verification
REQ-034 base=100,l0=2,l1=l2=l3=5,j0=1,j1=10,count=6,ready=1 -> out_addr 100,101,102,112,113,114; out_last on 114; done one cycle later.
REQ-035 Same job, out_ready=0 for 3 cycles after 101 -> 101 held 3 cycles, then 102; total 6 handshakes.
REQ-036 count=0 -> no out_valid, done pulse at start+2, busy high 2 cycles.
REQ-037 abort after 2nd handshake -> IDLE next cycle, no done, new start then yields base first.
REQ-038 start pulsed in RUN with different base -> ignored, current sequence unaffected.
REQ-039 l0=l1=l2=l3=0,j4=7,base=2^21-3,count=3 -> addresses 2^21-3, 4, 11 (mod wrap).
